// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package mcu_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_t;

  localparam logic [1:0] ALUCTL_ADD = 2'b00;
  localparam logic [1:0] ALUCTL_SUB = 2'b01;
  localparam logic [1:0] ALUCTL_AND = 2'b10;
  localparam logic [1:0] ALUCTL_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;

  // nzcv = {N, Z, C, V}; the reserved code 4'hf never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = ~z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = ~c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = ~n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = ~v;
      COND_HI: cond_holds = c & ~z;
      COND_LS: cond_holds = ~c | z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = ~z & (n == v);
      COND_LE: cond_holds = z | (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_check.sv
// NZCV flag register plus condition evaluator; the execute decision is latched once per
// instruction and also gates its own flag update.
module cond_check
  import mcu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,      // [1] writes N,Z  [0] writes C,V
  input  logic       cond_latch_i,
  output logic       cond_ex_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  always_comb begin
    flags_d   = flags_q;
    cond_ex_d = cond_ex_q;
    if (cond_latch_i) cond_ex_d = cond_holds(cond_i, flags_q);
    if (flag_w_i[1] && cond_ex_q) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] && cond_ex_q) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flags_q   <= FLAGS_RST;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex_o = cond_ex_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset controller: main FSM, ALU decode and write gating.
// Define MCU_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  state_o
);

  logic [3:0] cond, rd, cmd;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign unused_rn = Instr[7:4];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];

  logic mem_ok;
`ifdef MCU_MEMWAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  state_t state_q, state_d;
  logic       reg_w, mem_w, branch, alu_op, pc_update, cond_ex, no_write;
  logic [1:0] alu_ctl_dp, flag_w;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ok) state_d = StDecode;
      StDecode: begin
        unique case (op)
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  if (mem_ok) state_d = StMemWb;
      StMemWr:  if (mem_ok) state_d = StFetch;
      StExecR, StExecI: state_d = StAluWb;
      StMemWb, StAluWb, StBranch: state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  // Unknown commands run as ADD but must never reach the register file.
  always_comb begin
    alu_ctl_dp = ALUCTL_ADD;
    no_write   = 1'b0;
    case (cmd)
      CMD_ADD: alu_ctl_dp = ALUCTL_ADD;
      CMD_SUB: alu_ctl_dp = ALUCTL_SUB;
      CMD_AND: alu_ctl_dp = ALUCTL_AND;
      CMD_ORR: alu_ctl_dp = ALUCTL_ORR;
      CMD_CMP: begin
        alu_ctl_dp = ALUCTL_SUB;
        no_write   = 1'b1;
      end
      default: no_write = 1'b1;
    endcase
  end

  // Logical ops leave C and V untouched.
  assign flag_w = {alu_op & funct[0], alu_op & funct[0] & ~alu_ctl_dp[1]};

  always_comb begin
    pc_update  = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RD2;
    ALUControl = ALUCTL_ADD;
    unique case (state_q)
      StFetch: begin
        IRWrite   = mem_ok;
        pc_update = mem_ok;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      StMemAdr: ALUSrcB = SRCB_IMM;
      StMemRd:  AdrSrc = 1'b1;
      StMemWr: begin
        AdrSrc = 1'b1;
        mem_w  = mem_ok;
      end
      StMemWb: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
      end
      StExecR: begin
        alu_op     = 1'b1;
        ALUControl = alu_ctl_dp;
      end
      StExecI: begin
        ALUSrcB    = SRCB_IMM;
        alu_op     = 1'b1;
        ALUControl = alu_ctl_dp;
      end
      StAluWb: begin
        ResultSrc = RES_ALUOUT;
        reg_w     = 1'b1;
      end
      StBranch: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
      end
      default: ;
    endcase

    RegWrite = reg_w & cond_ex & ~(no_write & (op == 2'b00));
    MemWrite = mem_w & cond_ex;
    PCWrite  = pc_update | (cond_ex & (branch | (reg_w & (rd == 4'd15))));

    // Held in reset: no side effects, datapath steered as for a fetch.
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      ALUControl = ALUCTL_ADD;
      ResultSrc  = RES_ALURESULT;
    end
  end

  assign ImmSrc  = op;
  assign RegSrc  = {op == 2'b01, op == 2'b10};
  assign state_o = state_q;

  cond_check #(
    .FLAGS_RST(FLAGS_RST)
  ) u_cond_check (
    .clk_i       (clk),
    .rst_ni      (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .cond_latch_i(state_q == StDecode),
    .cond_ex_o   (cond_ex)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction phase lists and an NZCV model predict every control
// output each cycle; directed instructions pin latencies and write pulses.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  state_o;

  int          n_checks = 0;
  int          n_pass = 0;
  state_t      q[$];
  logic [3:0]  m_flags;
  logic        m_cond_ex;
  int          cnt_pc, cnt_rw, cnt_mw, cnt_ir;
  int unsigned ready_pct = 100;
  int          stall_first = 0;
  bit          rand_flags = 1'b0;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .FLAGS_RST(4'b0000)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .Instr     (Instr),
    .ALUFlags  (ALUFlags),
    .mem_ready (mem_ready),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .state_o   (state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // ARM rule: cond[3:1] picks a predicate, cond[0] inverts it; 1111 never executes.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic r;
    case (cond[3:1])
      3'd0:    r = f[2];
      3'd1:    r = f[1];
      3'd2:    r = f[3];
      3'd3:    r = f[0];
      3'd4:    r = f[1] & ~f[2];
      3'd5:    r = (f[3] == f[0]);
      3'd6:    r = ~f[2] & (f[3] == f[0]);
      default: r = 1'b1;
    endcase
    if (cond == 4'hf) return 1'b0;
    return cond[0] ? ~r : r;
  endfunction

  // {ALUControl, writes register}
  function automatic logic [2:0] dp_decode(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 3'b001;
      4'b0010: return 3'b011;
      4'b0000: return 3'b101;
      4'b1100: return 3'b111;
      4'b1010: return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic void build(input logic [19:0] ins);
    q.delete();
    q.push_back(StFetch);
    q.push_back(StDecode);
    case (ins[15:14])
      2'b00: begin
        q.push_back(ins[13] ? StExecI : StExecR);
        q.push_back(StAluWb);
      end
      2'b01: begin
        q.push_back(StMemAdr);
        if (ins[8]) begin
          q.push_back(StMemRd);
          q.push_back(StMemWb);
        end else begin
          q.push_back(StMemWr);
        end
      end
      2'b10:   q.push_back(StBranch);
      default: ;
    endcase
  endfunction

  task automatic step();
    state_t     p;
    logic       rdy, pc, ir, mw, rw, adr, srca, c_adr, c_res, c_a, c_b, c_alu;
    logic [1:0] op, res, srcb, alu;
    logic [3:0] rd;
    logic [2:0] dp;
    logic [15:0] exp_v, care, act;
    if (rand_flags) ALUFlags = 4'($urandom);
    #1;
    if (reset && q.size() == 0) build(Instr);
    p   = (q.size() != 0) ? q[0] : StFetch;
    rdy = 1'b1;
`ifdef MCU_MEMWAIT_EN
    rdy = mem_ready;
`endif
    op = Instr[15:14];
    rd = Instr[3:0];
    dp = dp_decode(Instr[12:9]);
    {adr, res, srca, srcb, alu} = '0;
    {c_adr, c_res, c_a, c_b, c_alu} = '0;
    pc = (p == StFetch && rdy) ||
         (m_cond_ex && (p == StBranch || ((p == StAluWb || p == StMemWb) && rd == 4'd15)));
    ir = (p == StFetch) && rdy;
    mw = (p == StMemWr) && rdy && m_cond_ex;
    rw = m_cond_ex && (p == StMemWb || (p == StAluWb && dp[0]));
    if (!reset) begin
      {pc, ir, mw, rw} = '0;
      p = StFetch;
    end
    case (p)
      StFetch:  begin c_adr = 1; c_a = 1; srca = 1; c_b = 1; srcb = 2'b10;
                      c_alu = 1; c_res = 1; res = 2'b10; end
      StDecode: begin c_a = 1; srca = 1; c_b = 1; srcb = 2'b10; c_alu = 1;
                      c_res = 1; res = 2'b10; end
      StMemAdr: begin c_a = 1; c_b = 1; srcb = 2'b01; c_alu = 1; end
      StMemRd, StMemWr: begin c_adr = 1; adr = 1; end
      StMemWb:  begin c_res = 1; res = 2'b01; end
      StExecR:  begin c_a = 1; c_b = 1; c_alu = 1; alu = dp[2:1]; end
      StExecI:  begin c_a = 1; c_b = 1; srcb = 2'b01; c_alu = 1; alu = dp[2:1]; end
      StAluWb:  begin c_res = 1; res = 2'b00; end
      StBranch: begin c_a = 1; c_b = 1; srcb = 2'b01; c_alu = 1; c_res = 1; res = 2'b10; end
      default:  ;
    endcase
    exp_v = {pc, adr, ir, mw, rw, res, srca, srcb, alu, op, op == 2'b01, op == 2'b10};
    care  = {1'b1, c_adr, 3'b111, {2{c_res}}, c_a, {2{c_b}}, {2{c_alu}}, 4'hf};
    act   = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegSrc};
    check($sformatf("ctl@%s", p.name()), 32'(act & care), 32'(exp_v & care));
    if (reset) check("state", 32'(state_o), 32'(p));
    cnt_pc += int'(PCWrite);
    cnt_rw += int'(RegWrite);
    cnt_mw += int'(MemWrite);
    cnt_ir += int'(IRWrite);
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_flags   = 4'b0000;
      m_cond_ex = 1'b0;
    end else begin
      if (p == StDecode) m_cond_ex = cond_ok(Instr[19:16], m_flags);
      if ((p == StExecR || p == StExecI) && Instr[8] && m_cond_ex) begin
        if (!dp[2]) m_flags = ALUFlags;
        else        m_flags[3:2] = ALUFlags[3:2];
      end
      if (!((p == StFetch || p == StMemRd || p == StMemWr) && !rdy)) void'(q.pop_front());
    end
    @(negedge clk);
  endtask

  // abort_at >= 0 holds reset low for two cycles starting at that cycle of the instruction.
  task automatic run_instr(input logic [19:0] ins, input int abort_at, output int cycles);
    Instr  = ins;
    cycles = 0;
    cnt_pc = 0;
    cnt_rw = 0;
    cnt_mw = 0;
    cnt_ir = 0;
    do begin
      mem_ready = (cycles < stall_first) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (cycles == abort_at) begin
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        cycles += 2;
      end else begin
        step();
        cycles++;
      end
    end while (q.size() != 0 && cycles < 64);
    if (cycles >= 64) begin
      n_checks++;
      $display("FAIL bound: instruction %h still running after %0d cycles", ins, cycles);
    end
  endtask

  initial begin
    int          cyc;
    logic [19:0] ins;
    int          ab;
    reset     = 1'b0;
    Instr     = '0;
    ALUFlags  = '0;
    mem_ready = 1'b1;
    m_flags   = '0;
    m_cond_ex = 1'b0;
    step();
    step();
    reset = 1'b1;

    ALUFlags = 4'hf;
    run_instr(20'hE0865, -1, cyc);
    check("add_cycles", cyc, 4);
    check("add_regwrite", cnt_rw, 1);
    check("add_pcwrite", cnt_pc, 1);
    run_instr(20'hE5912, -1, cyc);
    check("ldr_cycles", cyc, 5);
    check("ldr_regwrite", cnt_rw, 1);
    run_instr(20'hE5812, -1, cyc);
    check("str_cycles", cyc, 4);
    check("str_memwrite", cnt_mw, 1);
    check("str_regwrite", cnt_rw, 0);

    ALUFlags = 4'b0100;
    run_instr(20'hE0560, -1, cyc);
    check("subs_cycles", cyc, 4);
    ALUFlags = 4'b0000;
    run_instr(20'h0A000, -1, cyc);
    check("beq_taken_cycles", cyc, 3);
    check("beq_taken_pcwrite", cnt_pc, 2);
    run_instr(20'hE0560, -1, cyc);
    run_instr(20'h0A000, -1, cyc);
    check("beq_not_taken_pcwrite", cnt_pc, 1);
    run_instr(20'hEC000, -1, cyc);
    check("nop_cycles", cyc, 2);

    ALUFlags = 4'b0100;
    run_instr(20'hE0560, -1, cyc);
    run_instr(20'hE0865, 2, cyc);
    check("abort_regwrite", cnt_rw, 0);
    ALUFlags = 4'b0000;
    run_instr(20'h0A000, -1, cyc);
    check("flags_reset_pcwrite", cnt_pc, 1);

`ifdef MCU_MEMWAIT_EN
    stall_first = 3;
    run_instr(20'hE0865, -1, cyc);
    check("wait_add_cycles", cyc, 7);
    check("wait_irwrite", cnt_ir, 1);
    stall_first = 0;
`endif

    rand_flags = 1'b1;
    ready_pct  = 60;
    for (int i = 0; i < 400; i++) begin
      ins = 20'($urandom);
      if ($urandom_range(3) == 0) ins[3:0] = 4'hf;
      if ($urandom_range(1) == 0) ins[19:16] = 4'he;
      ab = ($urandom_range(15) == 0) ? int'($urandom_range(3, 1)) : -1;
      run_instr(ins, ab, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
